// File: rtl/uart_pkg.sv
// uart_pkg: transmitter state encoding and status-register bit positions shared by the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with extra pointer MSB for full/empty; ports clk, rst (async high), push/din, pop/dout (show-ahead), full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = wr_q == rd_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_bus.sv
// uart_tx_bus: bus-mapped UART transmitter (BASE+0 data write, BASE+1 status read) with TX FIFO; optional even parity via UART_PARITY_EN.
//   CLK, RESET (async high), BUS_DATA (inout, driven one cycle after a registered read), BUS_ADDR, BUS_WE,
//   UART_TX (serial out, idle high), TX_BUSY (frame on line or FIFO non-empty).
module uart_tx_bus import uart_pkg::*; #(
  parameter logic [7:0] BASE_ADDR  = 8'hE0,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115_200,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       UART_TX,
  output logic       TX_BUSY
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rd_data_q, rd_data_d, dout, status;
  logic tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d, rd_q, rd_d;
  logic wr, stat_rd, pop, full, empty, tick;
`ifdef UART_PARITY_EN
  logic par_q, par_d;
`endif
  assign wr      = BUS_WE && BUS_ADDR == BASE_ADDR;
  assign stat_rd = !BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1;
  assign tick    = cnt_q == CW'(DIV - 1);
  assign BUS_DATA = rd_q ? rd_data_q : 8'hzz;
  assign UART_TX = tx_q;
  assign TX_BUSY = busy_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RESET), .push(wr), .pop(pop), .din(BUS_DATA),
    .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy_q;
    status[ST_FULL] = full;
    status[ST_OVF]  = ovf_q;
    rd_d      = !BUS_WE && (BUS_ADDR == BASE_ADDR || stat_rd);
    rd_data_d = stat_rd ? status : 8'h00;
    ovf_d     = (wr && full) ? 1'b1 : stat_rd ? 1'b0 : ovf_q;
    busy_d    = state_q != IDLE || !empty;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
    tx_d    = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
    tx_d    = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
`endif
    case (state_q)
      IDLE, STOP:
        if (state_q == IDLE || tick) begin
          state_d = empty ? IDLE : START;
          pop     = !empty;
          sh_d    = empty ? sh_q : dout;
`ifdef UART_PARITY_EN
          par_d   = empty ? par_q : ^dout;
`endif
        end
      START:
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      DATA:
        if (tick) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
`ifdef UART_PARITY_EN
          state_d = bit_q == 3'd7 ? PARITY : DATA;
`else
          state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
        end
      PARITY:
        if (tick) state_d = STOP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_q      <= 1'b0;
      rd_data_q <= '0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
    end
endmodule

// File: tb/tb_uart_tx_bus.sv
// tb_uart_tx_bus: randomized self-checking bench comparing the serial line, busy flag and bus reads against frame-level expectations.
module tb_uart_tx_bus;
  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, oe = 1'b0;
  logic [7:0] addr = 8'h00, drv = 8'h00;
  tri1 [7:0] bus_data;
  logic uart_tx, tx_busy;
  int checks = 0, errors = 0;
  assign bus_data = oe ? drv : 8'hzz;
  always #5 clk = ~clk;
  uart_tx_bus #(.BASE_ADDR(8'hE0), .CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr), .BUS_WE(we),
    .UART_TX(uart_tx), .TX_BUSY(tx_busy)
  );
  function automatic void add_frame(input logic [7:0] b, inout bit line[$]);
    for (int i = 0; i < NB; i++) begin
      bit v;
      v = i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (NB == 11 && i == 9) ? ^b : 1'b1;
      repeat (DIV) line.push_back(v);
    end
  endfunction
  task automatic bus_idle();
    we = 1'b0; oe = 1'b0; addr = 8'h00;
  endtask
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; oe = 1'b1; addr = a; drv = d;
  endtask
  task automatic bus_rd(input logic [7:0] a);
    we = 1'b0; oe = 1'b0; addr = a;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL reset_bus got %h want ff", bus_data); end
    rst = 1'b0;
    bus_rd(8'hE1);
    @(negedge clk);
    bus_idle();
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", bus_data); end
    @(negedge clk);
    checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL reset_release got %h want ff", bus_data); end
  endtask
  task automatic test_frames(input string name, input logic [7:0] q[$]);
    bit line[$];
    int n;
    foreach (q[i]) add_frame(q[i], line);
    n = line.size();
    for (int k = 1; k <= n + 6; k++) begin
      logic et, eb;
      if (k <= q.size()) bus_wr(8'hE0, q[k-1]); else bus_idle();
      @(negedge clk);
      et = (k >= 3 && k - 3 < n) ? line[k-3] : 1'b1;
      eb = k >= 2 && k < 3 + n;
      checks++; if (uart_tx !== et) begin errors++; $display("FAIL %s tx cyc %0d got %b want %b", name, k, uart_tx, et); end
      checks++; if (tx_busy !== eb) begin errors++; $display("FAIL %s busy cyc %0d got %b want %b", name, k, tx_busy, eb); end
      if (!oe) begin
        checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL %s bus cyc %0d got %h want ff", name, k, bus_data); end
      end
    end
  endtask
  task automatic test_overflow();
    logic [7:0] q[$];
    bit line[$];
    int n;
    for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) add_frame(q[i], line);
    n = line.size();
    for (int k = 1; k <= n + 6; k++) begin
      logic et;
      logic [7:0] eb;
      if (k <= 7) bus_wr(8'hE0, q[k-1]);
      else if (k == 10 || k == 12) bus_rd(8'hE1);
      else if (k == 14) bus_rd(8'hE0);
      else if (k == 16) bus_rd(8'hE3);
      else if (k == 18) bus_wr(8'hE1, 8'($urandom));
      else if (k == 19) bus_wr(8'h10, 8'($urandom));
      else if (k == 20) bus_wr(8'hE2, 8'($urandom));
      else bus_idle();
      @(negedge clk);
      et = (k >= 3 && k - 3 < n) ? line[k-3] : 1'b1;
      eb = k == 10 ? 8'h07 : k == 12 ? 8'h03 : k == 14 ? 8'h00 : 8'hFF;
      checks++; if (uart_tx !== et) begin errors++; $display("FAIL ovf tx cyc %0d got %b want %b", k, uart_tx, et); end
      if (!oe) begin
        checks++; if (bus_data !== eb) begin errors++; $display("FAIL ovf bus cyc %0d got %h want %h", k, bus_data, eb); end
      end
    end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovf busy_end got %b want 0", tx_busy); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] q[$];
    bit line[$];
    int stop_k;
    q = {8'($urandom) & 8'hEF, 8'($urandom), 8'($urandom)};
    add_frame(q[0], line);
    stop_k = 3 + 5 * DIV + 4;
    for (int k = 1; k <= stop_k; k++) begin
      if (k <= 3) bus_wr(8'hE0, q[k-1]); else bus_idle();
      @(negedge clk);
      checks++; if (uart_tx !== ((k >= 3) ? line[k-3] : 1'b1)) begin errors++; $display("FAIL rstmid tx cyc %0d got %b", k, uart_tx); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid async_tx got %b want 1", uart_tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid async_busy got %b want 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid quiet_tx cyc %0d got %b want 1", k, uart_tx); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid quiet_busy cyc %0d got %b want 0", k, tx_busy); end
      checks++; if (bus_data !== 8'hFF) begin errors++; $display("FAIL rstmid bus cyc %0d got %h want ff", k, bus_data); end
    end
  endtask
  initial begin
    logic [7:0] q[$];
    test_reset();
    q = {8'hA5};
    test_frames("a5", q);
    q = {8'($urandom)};
    test_frames("single_rand0", q);
    q = {8'($urandom)};
    test_frames("single_rand1", q);
    q = {8'h01, 8'h02};
    test_frames("back_to_back", q);
    q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    test_frames("burst_rand", q);
    q = {8'h07};
    test_frames("par07", q);
    q = {8'h03};
    test_frames("par03", q);
    test_overflow();
    test_reset_mid();
    q = {8'($urandom), 8'($urandom)};
    test_frames("post_reset", q);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
